// File: rtl/rock_pkg.sv
// Shared types and default tuning constants for the rocking tuner.
package rock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Saturate clamps at the bound; bounce reflects off it and flips direction.
    typedef enum logic {
        MODE_SAT    = 1'b0,
        MODE_BOUNCE = 1'b1
    } step_mode_t;

    typedef enum logic [1:0] {
        PULSE_NONE = 2'd0,
        PULSE_INC  = 2'd1,
        PULSE_DEC  = 2'd2
    } pulse_t;

    localparam int DEF_AMP_W        = 8;
    localparam int DEF_FREQ_W       = 8;
    localparam int DEF_AMP_INIT     = 128;
    localparam int DEF_AMP_MIN      = 32;
    localparam int DEF_AMP_MAX      = 200;
    localparam int DEF_AMP_STEP     = 16;
    localparam int DEF_FREQ_INIT    = 60;
    localparam int DEF_FREQ_MIN     = 40;
    localparam int DEF_FREQ_MAX     = 80;
    localparam int DEF_FREQ_STEP    = 10;
    localparam int DEF_SETTLE_TICKS = 4;
    localparam int DEF_ERR_LIMIT    = 8;

endpackage

// File: rtl/rock_tuner_bound_step.sv
// Combinational bounded stepper: one step of STEP in the requested direction,
// either clamped to [MIN,MAX] or bounced back off the violated bound.
module bound_step
    import rock_pkg::*;
#(
    parameter int W    = 8,
    parameter int MIN  = 0,
    parameter int MAX  = 255,
    parameter int STEP = 1
) (
    input  logic       [W-1:0] val,
    input  logic               dir_up,
    input  step_mode_t         mode,
    output logic       [W-1:0] nxt,
    output logic               nxt_up,
    output pulse_t             pulse
);

    // One bit of headroom so the sum/compare never wraps.
    logic [W:0] up_sum;
    logic [W:0] dn_diff;
    logic       over;
    logic       under;

    assign up_sum  = {1'b0, val} + (W+1)'(STEP);
    assign dn_diff = {1'b0, val} - (W+1)'(STEP);
    assign over    = up_sum > (W+1)'(MAX);
    assign under   = {1'b0, val} < ((W+1)'(MIN) + (W+1)'(STEP));

    // Pick next value, direction and pulse kind for the selected mode.
    always_comb begin
        nxt    = val;
        nxt_up = dir_up;
        pulse  = PULSE_NONE;
        if (mode == MODE_SAT) begin
            if (dir_up) begin
                nxt   = over ? W'(MAX) : up_sum[W-1:0];
                pulse = PULSE_INC;
            end else begin
                nxt   = under ? W'(MIN) : dn_diff[W-1:0];
                pulse = PULSE_DEC;
            end
        end else begin
            if (dir_up && over) begin
                nxt    = dn_diff[W-1:0];
                nxt_up = 1'b0;
                pulse  = PULSE_DEC;
            end else if (dir_up) begin
                nxt   = up_sum[W-1:0];
                pulse = PULSE_INC;
            end else if (under) begin
                nxt    = up_sum[W-1:0];
                nxt_up = 1'b1;
                pulse  = PULSE_INC;
            end else begin
                nxt   = dn_diff[W-1:0];
                pulse = PULSE_DEC;
            end
        end
    end

endmodule

// File: rtl/rock_tuner.sv
// Closed-loop rocking tuner: settles for a window of sample ticks, then
// backs amplitude off while calm, searches frequency while stressed, and
// latches a fault after too many stressed evaluations in a row.
module rock_tuner
    import rock_pkg::*;
#(
    parameter int AMP_W        = DEF_AMP_W,
    parameter int FREQ_W       = DEF_FREQ_W,
    parameter int AMP_INIT     = DEF_AMP_INIT,
    parameter int AMP_MIN      = DEF_AMP_MIN,
    parameter int AMP_MAX      = DEF_AMP_MAX,
    parameter int AMP_STEP     = DEF_AMP_STEP,
    parameter int FREQ_INIT    = DEF_FREQ_INIT,
    parameter int FREQ_MIN     = DEF_FREQ_MIN,
    parameter int FREQ_MAX     = DEF_FREQ_MAX,
    parameter int FREQ_STEP    = DEF_FREQ_STEP,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS,
    parameter int ERR_LIMIT    = DEF_ERR_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic              stress,
    output logic              run,
    output logic [AMP_W-1:0]  amp,
    output logic [FREQ_W-1:0] freq,
    output logic              amp_dec,
    output logic              amp_inc,
    output logic              freq_inc,
    output logic              freq_dec,
    output logic              calm,
    output logic              error,
    output logic [1:0]        state
);

    localparam int TW = $clog2(SETTLE_TICKS + 1);
    localparam int FW = $clog2(ERR_LIMIT + 1);

    if (!(AMP_MIN <= AMP_INIT && AMP_INIT <= AMP_MAX &&
          FREQ_MIN <= FREQ_INIT && FREQ_INIT <= FREQ_MAX &&
          FREQ_MAX - FREQ_MIN >= FREQ_STEP &&
          SETTLE_TICKS >= 1 && ERR_LIMIT >= 1)) begin : g_param_check
        $error("rock_tuner: illegal parameter set");
    end

    state_t              state_q, state_d;
    logic                run_q, run_d, calm_q, calm_d, error_q, error_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic                ainc_q, ainc_d, adec_q, adec_d;
    logic                finc_q, finc_d, fdec_q, fdec_d;
    logic                dir_up_q, dir_up_d, last_dec_q, last_dec_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [FW-1:0]       fail_q, fail_d;

    logic [AMP_W-1:0]    amp_nxt;
    logic                amp_nxt_up;
    pulse_t              amp_pulse;
    logic [FREQ_W-1:0]   freq_nxt;
    logic                freq_nxt_up;
    pulse_t              freq_pulse;

    // Stressed -> restore amplitude upward, calm -> back it off downward.
    bound_step #(.W(AMP_W), .MIN(AMP_MIN), .MAX(AMP_MAX), .STEP(AMP_STEP)) u_amp_step (
        .val(amp_q), .dir_up(stress), .mode(MODE_SAT),
        .nxt(amp_nxt), .nxt_up(amp_nxt_up), .pulse(amp_pulse)
    );

    bound_step #(.W(FREQ_W), .MIN(FREQ_MIN), .MAX(FREQ_MAX), .STEP(FREQ_STEP)) u_freq_step (
        .val(freq_q), .dir_up(dir_up_q), .mode(MODE_BOUNCE),
        .nxt(freq_nxt), .nxt_up(freq_nxt_up), .pulse(freq_pulse)
    );

    // Next-state and next-output decision; every output is registered below.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        calm_d     = calm_q;
        error_d    = error_q;
        amp_d      = amp_q;
        freq_d     = freq_q;
        dir_up_d   = dir_up_q;
        last_dec_d = last_dec_q;
        tick_d     = tick_q;
        fail_d     = fail_q;
        ainc_d     = 1'b0;
        adec_d     = 1'b0;
        finc_d     = 1'b0;
        fdec_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = SETTLE;
                    run_d      = 1'b1;
                    amp_d      = AMP_W'(AMP_INIT);
                    freq_d     = FREQ_W'(FREQ_INIT);
                    dir_up_d   = 1'b1;
                    fail_d     = '0;
                    tick_d     = '0;
                    last_dec_d = 1'b0;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                    amp_d   = '0;
                    freq_d  = '0;
                end else if (sample_tick) begin
                    if (tick_q == TW'(SETTLE_TICKS - 1)) begin
                        tick_d = '0;
                        if (stress && (fail_q + FW'(1)) == FW'(ERR_LIMIT)) begin
                            state_d = FAULT;
                            error_d = 1'b1;
                            run_d   = 1'b0;
                            amp_d   = AMP_W'(AMP_MIN);
                        end else if (stress && last_dec_q) begin
                            // Last back-off made things worse: undo it.
                            amp_d      = amp_nxt;
                            ainc_d     = (amp_pulse == PULSE_INC);
                            last_dec_d = ~amp_nxt_up;
                            fail_d     = fail_q + FW'(1);
                        end else if (stress) begin
                            freq_d   = freq_nxt;
                            dir_up_d = freq_nxt_up;
                            finc_d   = (freq_pulse == PULSE_INC);
                            fdec_d   = (freq_pulse == PULSE_DEC);
                            fail_d   = fail_q + FW'(1);
                        end else if (amp_q == AMP_W'(AMP_MIN)) begin
                            state_d = HOLD;
                            calm_d  = 1'b1;
                            fail_d  = '0;
                        end else begin
                            // A downward amp move arms the regression undo.
                            amp_d      = amp_nxt;
                            adec_d     = (amp_pulse == PULSE_DEC);
                            last_dec_d = ~amp_nxt_up;
                            fail_d     = '0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                    calm_d  = 1'b0;
                    amp_d   = '0;
                    freq_d  = '0;
                end else if (sample_tick && stress) begin
                    state_d    = SETTLE;
                    calm_d     = 1'b0;
                    amp_d      = AMP_W'(AMP_INIT);
                    last_dec_d = 1'b0;
                    fail_d     = '0;
                    tick_d     = '0;
                end
            end
            FAULT: ;
            default: ;
        endcase
    end

    // State and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            calm_q     <= 1'b0;
            error_q    <= 1'b0;
            amp_q      <= '0;
            freq_q     <= '0;
            dir_up_q   <= 1'b0;
            last_dec_q <= 1'b0;
            tick_q     <= '0;
            fail_q     <= '0;
            ainc_q     <= 1'b0;
            adec_q     <= 1'b0;
            finc_q     <= 1'b0;
            fdec_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            calm_q     <= calm_d;
            error_q    <= error_d;
            amp_q      <= amp_d;
            freq_q     <= freq_d;
            dir_up_q   <= dir_up_d;
            last_dec_q <= last_dec_d;
            tick_q     <= tick_d;
            fail_q     <= fail_d;
            ainc_q     <= ainc_d;
            adec_q     <= adec_d;
            finc_q     <= finc_d;
            fdec_q     <= fdec_d;
        end
    end

    assign state    = state_q;
    assign run      = run_q;
    assign calm     = calm_q;
    assign error    = error_q;
    assign amp      = amp_q;
    assign freq     = freq_q;
    assign amp_inc  = ainc_q;
    assign amp_dec  = adec_q;
    assign freq_inc = finc_q;
    assign freq_dec = fdec_q;

endmodule

// File: tb/tb_rock_tuner.sv
// Directed bench for rock_tuner: an arithmetic reference model checked every
// cycle, plus hand-computed expectations along the test plan.
module tb_rock_tuner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       sample_tick = 1'b0;
    logic       stress = 1'b0;
    logic       run, amp_dec, amp_inc, freq_inc, freq_dec, calm, error;
    logic [7:0] amp, freq;
    logic [1:0] state;

    int n_pass = 0;
    int n_total = 0;

    rock_tuner dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .stress(stress), .run(run), .amp(amp), .freq(freq),
        .amp_dec(amp_dec), .amp_inc(amp_inc), .freq_inc(freq_inc),
        .freq_dec(freq_dec), .calm(calm), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 settle, 2 hold, 3 fault.
    int m_state = 0, m_amp = 0, m_freq = 0, m_tick = 0, m_fail = 0;
    bit m_up = 0, m_last = 0, m_ai = 0, m_ad = 0, m_fi = 0, m_fd = 0;

    always @(posedge clk) begin
        m_ai = 0; m_ad = 0; m_fi = 0; m_fd = 0;
        if (reset) begin
            m_state = 0; m_amp = 0; m_freq = 0; m_tick = 0; m_fail = 0;
            m_up = 0; m_last = 0;
        end else if (m_state == 0) begin
            if (enable) begin
                m_state = 1; m_amp = 128; m_freq = 60; m_up = 1;
                m_tick = 0; m_fail = 0; m_last = 0;
            end
        end else if ((m_state == 1 || m_state == 2) && !enable) begin
            m_state = 0; m_amp = 0; m_freq = 0;
        end else if (m_state == 2) begin
            if (sample_tick && stress) begin
                m_state = 1; m_amp = 128; m_last = 0; m_fail = 0; m_tick = 0;
            end
        end else if (m_state == 1 && sample_tick) begin
            m_tick = m_tick + 1;
            if (m_tick == 4) begin
                m_tick = 0;
                if (stress && m_fail + 1 == 8) begin
                    m_state = 3; m_amp = 32;
                end else if (stress && m_last) begin
                    m_amp = (m_amp + 16 > 200) ? 200 : m_amp + 16;
                    m_ai = 1; m_last = 0; m_fail++;
                end else if (stress) begin
                    m_fail++;
                    if (m_up && m_freq + 10 > 80) begin
                        m_up = 0; m_freq -= 10; m_fd = 1;
                    end else if (!m_up && m_freq - 10 < 40) begin
                        m_up = 1; m_freq += 10; m_fi = 1;
                    end else if (m_up) begin
                        m_freq += 10; m_fi = 1;
                    end else begin
                        m_freq -= 10; m_fd = 1;
                    end
                end else if (m_amp == 32) begin
                    m_state = 2; m_fail = 0;
                end else begin
                    m_amp = (m_amp - 16 < 32) ? 32 : m_amp - 16;
                    m_ad = 1; m_last = 1; m_fail = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [24:0] dv, mv;
        logic [1:0]  ms;
        logic [7:0]  ma, mf;
        ms = m_state[1:0];
        ma = m_amp[7:0];
        mf = m_freq[7:0];
        dv = {state, run, amp, freq, amp_inc, amp_dec, freq_inc, freq_dec, calm, error};
        mv = {ms, (m_state == 1 || m_state == 2), ma, mf, m_ai, m_ad, m_fi, m_fd,
              (m_state == 2), (m_state == 3)};
        n_total++;
        if (dv === mv) n_pass++;
        else $display("FAIL cycle t=%0t dut=%h model=%h", $time, dv, mv);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input bit en, input bit tk, input bit st);
        enable = en; sample_tick = tk; stress = st;
        @(posedge clk);
        #1;
    endtask

    int c_amp, c_freq, c_state, c_ai, c_ad, c_fi, c_fd;

    // One sample tick, outputs captured right after it, then two quiet cycles.
    task automatic tick(input bit st);
        cyc(1, 1, st);
        c_amp = amp; c_freq = freq; c_state = state;
        c_ai = amp_inc; c_ad = amp_dec; c_fi = freq_inc; c_fd = freq_dec;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
    endtask

    int fexp[7] = '{70, 80, 70, 60, 50, 40, 50};
    int n_dec;

    initial begin
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset_state", state, 0);
        chk("reset_amp", amp, 0);
        chk("reset_run", run, 0);
        reset = 1'b0;

        // Calm descent to HOLD.
        cyc(1, 0, 0);
        chk("start_amp", amp, 128);
        chk("start_run", run, 1);
        n_dec = 0;
        for (int e = 1; e <= 6; e++) begin
            repeat (3) tick(0);
            tick(0);
            chk("descent_amp", c_amp, 128 - 16 * e);
            n_dec += c_ad;
        end
        chk("descent_dec_pulses", n_dec, 6);
        repeat (4) tick(0);
        chk("hold_state", state, 2);
        chk("hold_calm", calm, 1);
        chk("hold_run", run, 1);
        chk("hold_amp", amp, 32);

        // Stress in HOLD restarts settling.
        tick(1);
        chk("rearm_state", c_state, 1);
        chk("rearm_amp", c_amp, 128);
        chk("rearm_calm", calm, 0);

        // Back-off, regression undo, then frequency search.
        repeat (4) tick(0);
        chk("backoff_amp", c_amp, 112);
        chk("backoff_pulse", c_ad, 1);
        repeat (4) tick(1);
        chk("undo_amp", c_amp, 128);
        chk("undo_pulse", c_ai, 1);
        chk("undo_freq", c_freq, 60);
        repeat (4) tick(1);
        chk("search_freq", c_freq, 70);
        chk("search_pulse", c_fi, 1);

        // Disable mid-window, then a fresh window is required.
        tick(0);
        tick(0);
        cyc(0, 0, 0);
        chk("disable_state", state, 0);
        chk("disable_run", run, 0);
        chk("disable_amp", amp, 0);
        cyc(1, 0, 0);
        repeat (3) tick(0);
        chk("fresh_window_amp", amp, 128);
        tick(0);
        chk("fresh_eval_amp", c_amp, 112);

        // Constant stress: bouncing search then fault.
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
        cyc(1, 0, 0);
        for (int e = 0; e < 7; e++) begin
            repeat (3) tick(1);
            tick(1);
            chk("bounce_freq", c_freq, fexp[e]);
        end
        repeat (4) tick(1);
        chk("fault_state", state, 3);
        chk("fault_error", error, 1);
        chk("fault_amp", amp, 32);
        chk("fault_run", run, 0);
        chk("fault_freq", freq, 50);
        cyc(0, 1, 1);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("fault_sticky_state", state, 3);
        chk("fault_sticky_error", error, 1);

        // Reset between edges has no effect until the edge.
        reset = 1'b1;
        #3;
        chk("midcycle_state", state, 3);
        chk("midcycle_error", error, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("edge_reset_state", state, 0);
        chk("edge_reset_error", error, 0);
        chk("edge_reset_amp", amp, 0);
        chk("edge_reset_freq", freq, 0);
        cyc(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rock_tuner.md
Name: rock_tuner

Overview:
Parametrised successor to the single-channel rocking pathfinder. It closed-loop tunes rocking amplitude and frequency from a binary stress sensor, sampled on a tick strobe. Behaviour beyond the old block: a settle window before each decision, bounded bouncing frequency search, amplitude back-off with regression undo, a calm-hold state, and a sticky fault after repeated failures. Sits between the stress-sensor front end and the motor drive.

Parameters:
AMP_W, 8, amplitude width
FREQ_W, 8, frequency width
AMP_INIT, 128, amplitude loaded on start
AMP_MIN, 32, amplitude floor and fault-safe value
AMP_MAX, 200, amplitude ceiling
AMP_STEP, 16, amplitude step
FREQ_INIT, 60, frequency loaded on start
FREQ_MIN, 40, frequency lower bound
FREQ_MAX, 80, frequency upper bound
FREQ_STEP, 10, frequency step
SETTLE_TICKS, 4, sample ticks per evaluation, >=1
ERR_LIMIT, 8, consecutive stressed evaluations that cause fault, >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request
sample_tick  in  1  one-cycle strobe marking a valid stress sample
stress  in  1  1 = baby stressed; sampled only when sample_tick=1
run  out  1  motor enable
amp  out  AMP_W  amplitude setpoint
freq  out  FREQ_W  frequency setpoint
amp_dec  out  1  one-cycle pulse, amplitude lowered
amp_inc  out  1  one-cycle pulse, amplitude restored
freq_inc  out  1  one-cycle pulse, frequency raised
freq_dec  out  1  one-cycle pulse, frequency lowered
calm  out  1  high in HOLD
error  out  1  sticky fault flag
state  out  2  IDLE=0, SETTLE=1, HOLD=2, FAULT=3

Behaviour:
- Reset, sampled on the clk edge only:
  - state=IDLE; all outputs 0; internal tick_cnt, fail_cnt, dir(up), last_dec cleared.
- All outputs are registered. Pulses are high for exactly the cycle after the deciding edge.
- IDLE: run=0, amp=0, freq=0.
  - enable=1 -> SETTLE. Load amp=AMP_INIT, freq=FREQ_INIT, dir=up, fail_cnt=0, tick_cnt=0, last_dec=0.
- enable=0 in SETTLE or HOLD -> IDLE on the next edge. FAULT ignores enable.
- SETTLE: run=1.
  - Each sample_tick increments tick_cnt.
  - The tick with tick_cnt==SETTLE_TICKS-1 is an evaluation; tick_cnt returns to 0.
- Evaluation priority, in this order:
  1. stress=1 and fail_cnt+1==ERR_LIMIT -> FAULT. error=1, run=0, amp=AMP_MIN, freq held, no pulse.
  2. stress=1 and last_dec=1 (regression) -> amp=min(amp+AMP_STEP, AMP_MAX), amp_inc pulse, last_dec=0, fail_cnt+1.
  3. stress=1 otherwise -> frequency step in dir, fail_cnt+1.
     - If dir=up and freq+FREQ_STEP>FREQ_MAX: dir=down, freq-=FREQ_STEP, freq_dec pulse.
     - If dir=down and freq-FREQ_STEP<FREQ_MIN: dir=up, freq+=FREQ_STEP, freq_inc pulse.
     - Otherwise step in dir with the matching pulse.
  4. stress=0 and amp==AMP_MIN -> HOLD, calm=1, fail_cnt=0.
  5. stress=0 otherwise -> amp=max(amp-AMP_STEP, AMP_MIN), amp_dec pulse, last_dec=1, fail_cnt=0.
- Bound arithmetic is done one bit wider than the operand so no wrap-around occurs.
- HOLD: run=1, amp and freq held.
  - A tick with stress=1 -> SETTLE. Reload amp=AMP_INIT, last_dec=0, fail_cnt=0, tick_cnt=0. freq and dir kept.
- FAULT: left only by reset.
- sample_tick while in IDLE or FAULT is ignored.
- Parameter legality (AMP_MIN<=AMP_INIT<=AMP_MAX, FREQ_MIN<=FREQ_INIT<=FREQ_MAX, FREQ_MAX-FREQ_MIN>=FREQ_STEP) is checked with an elaboration-time assertion.

Decomposition:
- Package rock_pkg: state enum (IDLE, SETTLE, HOLD, FAULT) and the default constants listed above.
- One sub-module, bound_step: a combinational bounded stepper with a mode input (saturate or bounce).
  - Returns the next value, the next direction and the pulse kind.
  - Instantiated once for amplitude (saturate) and once for frequency (bounce).

Test Plan:
- Reset, enable=1, stress=0, ticks every 3 cycles -> amp 128,112,...,32 after 6 evaluations with 6 amp_dec pulses; 7th evaluation (tick 28) -> HOLD, calm=1, run=1.
- stress=1 constantly -> freq after evaluations 1-7 is 70,80,70,60,50,40,50. 8th evaluation -> FAULT, error=1, amp=32, run=0, freq=50; enable toggling has no effect.
- One calm evaluation (amp=112, amp_dec), then stress -> amp=128, amp_inc, freq=60 unchanged; next stressed evaluation -> freq=70, freq_inc.
- enable=0 after 2 ticks in SETTLE -> IDLE next edge, run=0, amp=0. Re-enable -> 4 fresh ticks needed before the first evaluation.
- From HOLD, tick with stress=1 -> SETTLE, amp=128, calm=0, fail_cnt=0.
- reset=1 held between clk edges in FAULT -> no change; cleared at the edge (state=0, error=0, all outputs 0).
